multdiv_issue: RTL and testbench
================================

Name: multdiv_issue

Overview:
- Pipeline-side controller directly upstream of the multi-cycle multiplier/divider pair.
- Accepts a mult/div instruction from the execute stage, latches operands, and issues a one-cycle ctrl_MULT or ctrl_DIV pulse.
- Stalls the pipeline until the unit raises ready, then presents one registered writeback (result to rd, or exception code to rstatus).

Parameters:
- RSTATUS_REG, 30, register index written on exception
- EXC_MULT_CODE, 4, rstatus value on multiply exception
- EXC_DIV_CODE, 5, rstatus value on divide exception (incl. divide by zero)
- TIMEOUT_CYCLES, 40, WAIT-cycle limit; used only with MULTDIV_TIMEOUT_EN

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  execute stage holds a mult/div instruction this cycle
- is_div  in  1  1 = divide, 0 = multiply; sampled with start
- operand_a  in  32  dividend / multiplicand
- operand_b  in  32  divisor / multiplier
- dest_reg  in  5  rd of the instruction
- unit_result  in  32  product or quotient from the unit
- unit_exception  in  1  unit overflow / divide-by-zero flag
- unit_ready  in  1  unit completion flag
- ctrl_MULT  out  1  one-cycle multiply start pulse
- ctrl_DIV  out  1  one-cycle divide start pulse
- data_operandA  out  32  latched operand_a, held stable through the operation
- data_operandB  out  32  latched operand_b, held stable through the operation
- stall  out  1  freeze fetch/decode/execute
- busy  out  1  state is not IDLE
- wb_valid  out  1  one-cycle writeback strobe
- wb_reg  out  5  writeback register index
- wb_data  out  32  writeback value
- wb_exception  out  1  writeback is an exception code

Behaviour:
- Reset (async, immediate): state=IDLE; ctrl_MULT, ctrl_DIV, wb_valid, wb_exception, busy = 0; data_operandA/B, wb_reg, wb_data, op_is_div, cycle counter = 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if start, latch operand_a/b, dest_reg, is_div, then go to ISSUE.
- ISSUE: exactly one cycle.
  - ctrl_DIV = op_is_div; ctrl_MULT = !op_is_div (registered, high only in this state).
  - unit_ready is ignored here, because the unit may show a stale ready.
  - Next state is WAIT.
- WAIT: on unit_ready=1, capture results and go to DONE.
  - No exception: wb_data = unit_result, wb_reg = latched rd, wb_exception = 0.
  - Exception: wb_data = EXC_DIV_CODE or EXC_MULT_CODE per op_is_div, wb_reg = RSTATUS_REG, wb_exception = 1.
- DONE: wb_valid = 1 for exactly this cycle; wb_* hold the captured values.
  - If start is high, latch the new instruction and go to ISSUE (back-to-back, no idle bubble).
  - Otherwise go to IDLE.
- wb_reg/wb_data/wb_exception hold their values until the next capture; only wb_valid qualifies them.
- stall = (start & state==IDLE) | state==ISSUE | state==WAIT | (start & state==DONE).
  - stall is combinational from start and registered state only.
  - stall is low in DONE without start, so the pipeline advances on the writeback cycle.
- start during ISSUE/WAIT is ignored; the stall holds the instruction upstream.
- dest_reg = 0 without exception: wb_valid still pulses with wb_reg=0; the regfile discards it.
- Latency: start at edge N → ctrl pulse cycle N+1 → WAIT from N+2 → wb_valid the cycle after ready is sampled.
- Reset in ISSUE/WAIT abandons the operation. A later stale unit_ready seen in IDLE is ignored, with no writeback.
- data_operandA/B change only on instruction acceptance, never mid-operation.

Optional Feature:
- Macro: MULTDIV_TIMEOUT_EN.
- Defined:
  - A 6-bit counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without unit_ready, go to DONE with wb_exception = 1, wb_reg = RSTATUS_REG, and wb_data = the op's exception code.
  - Ready and timeout in the same cycle: ready wins.
- Undefined: no counter; WAIT lasts indefinitely until unit_ready.

Test Plan:
- Multiply: start, is_div=0, a=6, b=7, rd=3; ready 17 cycles later with result 42.
  - ctrl_MULT pulses exactly one cycle.
  - stall high until the DONE cycle.
  - wb_valid=1 for one cycle with wb_reg=3, wb_data=42, wb_exception=0.
- Divide by zero: is_div=1, a=100, b=0, rd=8; unit_exception=1 with ready.
  - ctrl_DIV single pulse.
  - wb_reg=30, wb_data=5, wb_exception=1.
- Back-to-back: second start (div 100/7, rd=9) asserted in the DONE cycle of a mult.
  - Immediately ISSUE with ctrl_DIV pulse.
  - Then wb_data=14, wb_reg=9, with no idle cycle.
- Stale ready: unit_ready held high during ISSUE → ignored; completion only on ready sampled in WAIT.
- Reset mid-WAIT: assert reset 5 cycles into a div.
  - All outputs 0 immediately.
  - A subsequent unit_ready produces no wb_valid.
- MULTDIV_TIMEOUT_EN defined, TIMEOUT_CYCLES=40, ready never asserted.
  - DONE after 40 WAIT cycles with wb_reg=30, wb_data=4 (mult) or 5 (div).

Source files
------------

// File: rtl/multdiv_issue.sv
// -----------------------------------------------------------------------------
// multdiv_issue
//
// Pipeline-side controller for the multi-cycle multiplier/divider pair.
// It accepts a mult/div instruction from execute and latches its operands.
// It then fires a one-cycle ctrl_MULT or ctrl_DIV pulse and stalls the
// pipeline until the unit reports ready. Finally it presents one registered
// writeback: the result goes to rd, or an exception code goes to rstatus.
//
// Optional feature (compile-time macro MULTDIV_TIMEOUT_EN):
//   A WAIT-cycle watchdog. After TIMEOUT_CYCLES WAIT cycles without
//   unit_ready, the controller writes back the op's exception code to
//   RSTATUS_REG. Without the macro, WAIT lasts until unit_ready.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   start, is_div        instruction present in execute / divide select
//   operand_a/b          dividend|multiplicand / divisor|multiplier
//   dest_reg             rd of the instruction
//   unit_result          product or quotient from the unit
//   unit_exception       overflow / divide-by-zero flag from the unit
//   unit_ready           unit completion flag
//   ctrl_MULT, ctrl_DIV  one-cycle start pulses to the unit
//   data_operandA/B      latched operands, stable through the operation
//   stall                freezes fetch/decode/execute
//   busy                 controller is not idle
//   wb_valid             one-cycle writeback strobe
//   wb_reg/data/exception writeback index, value, exception marker
// -----------------------------------------------------------------------------
module multdiv_issue #(
  parameter int RSTATUS_REG    = 30,
  parameter int EXC_MULT_CODE  = 4,
  parameter int EXC_DIV_CODE   = 5,
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        is_div,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [4:0]  dest_reg,
  input  logic [31:0] unit_result,
  input  logic        unit_exception,
  input  logic        unit_ready,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] data_operandA,
  output logic [31:0] data_operandB,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        wb_exception
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t      state;
  logic        op_is_div;
  logic [4:0]  op_rd;
  logic        accept;
  logic [31:0] exc_code;

`ifdef MULTDIV_TIMEOUT_EN
  logic [5:0]  wait_cnt;
`endif

  // A new instruction is taken only when idle or on the writeback cycle.
  // Starts during ISSUE/WAIT stay upstream, held there by the stall.
  assign accept   = start && (state == S_IDLE || state == S_DONE);
  assign stall    = accept || state == S_ISSUE || state == S_WAIT;
  assign busy     = (state != S_IDLE);
  assign exc_code = op_is_div ? 32'(EXC_DIV_CODE) : 32'(EXC_MULT_CODE);

  // NOTE: every register here is state, so all of them use non-blocking
  // assignments. A blocking assignment would let one register's new value
  // leak into another register's update in the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      ctrl_MULT     <= 1'b0;
      ctrl_DIV      <= 1'b0;
      data_operandA <= '0;
      data_operandB <= '0;
      op_is_div     <= 1'b0;
      op_rd         <= '0;
      wb_valid      <= 1'b0;
      wb_reg        <= '0;
      wb_data       <= '0;
      wb_exception  <= 1'b0;
`ifdef MULTDIV_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      // The ctrl pulses and wb_valid are single-cycle strobes.
      // They are raised only on the transition that needs them.
      ctrl_MULT <= 1'b0;
      ctrl_DIV  <= 1'b0;
      wb_valid  <= 1'b0;

      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            data_operandA <= operand_a;
            data_operandB <= operand_b;
            op_is_div     <= is_div;
            op_rd         <= dest_reg;
            ctrl_DIV      <= is_div;
            ctrl_MULT     <= !is_div;
            state         <= S_ISSUE;
          end else begin
            state <= S_IDLE;
          end
        end

        // unit_ready may still be high from the previous operation,
        // so it is not looked at here.
        S_ISSUE: begin
          state <= S_WAIT;
`ifdef MULTDIV_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end

        S_WAIT: begin
          if (unit_ready) begin
            state    <= S_DONE;
            wb_valid <= 1'b1;
            if (unit_exception) begin
              wb_reg       <= 5'(RSTATUS_REG);
              wb_data      <= exc_code;
              wb_exception <= 1'b1;
            end else begin
              wb_reg       <= op_rd;
              wb_data      <= unit_result;
              wb_exception <= 1'b0;
            end
          end
`ifdef MULTDIV_TIMEOUT_EN
          // Ready is checked first, so it wins over a same-cycle timeout.
          else if (wait_cnt == 6'(TIMEOUT_CYCLES - 1)) begin
            state        <= S_DONE;
            wb_valid     <= 1'b1;
            wb_reg       <= 5'(RSTATUS_REG);
            wb_data      <= exc_code;
            wb_exception <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 6'd1;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_issue.sv
// -----------------------------------------------------------------------------
// tb_multdiv_issue
//
// Directed testbench for multdiv_issue. Inputs change and outputs are checked
// on the falling clock edge. The DUT registers update on the rising edge.
// -----------------------------------------------------------------------------
module tb_multdiv_issue;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        is_div;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  dest_reg;
  logic [31:0] unit_result;
  logic        unit_exception;
  logic        unit_ready;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        stall;
  logic        busy;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_exception;

  int total = 0;
  int bad   = 0;

  multdiv_issue dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .is_div         (is_div),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .dest_reg       (dest_reg),
    .unit_result    (unit_result),
    .unit_exception (unit_exception),
    .unit_ready     (unit_ready),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .stall          (stall),
    .busy           (busy),
    .wb_valid       (wb_valid),
    .wb_reg         (wb_reg),
    .wb_data        (wb_data),
    .wb_exception   (wb_exception)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  // Present an instruction for one rising edge, then withdraw start.
  task automatic launch(input logic d, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    start = 1'b1; is_div = d; operand_a = a; operand_b = b; dest_reg = rd;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; is_div = 1'b0; operand_a = '0; operand_b = '0;
    dest_reg = '0; unit_result = '0; unit_exception = 1'b0; unit_ready = 1'b0;
    tick(); tick();
    total++;
    if ({ctrl_MULT, ctrl_DIV, stall, busy, wb_valid, wb_exception} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000000",
                      {ctrl_MULT, ctrl_DIV, stall, busy, wb_valid, wb_exception});
    end
    total++;
    if ({data_operandA, data_operandB, wb_reg, wb_data} !== '0) begin
      bad++; $display("FAIL reset_data: got A=%0h B=%0h reg=%0d data=%0h want all 0",
                      data_operandA, data_operandB, wb_reg, wb_data);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_multiply();
    int extra_stall_low = 0;
    int extra_valid     = 0;
    start = 1'b1; is_div = 1'b0; operand_a = 32'd6; operand_b = 32'd7; dest_reg = 5'd3;
    #1;
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL mult_stall_idle: got %b want 1", stall); end
    tick();  // now ISSUE
    start = 1'b0;
    total++;
    if ({ctrl_MULT, ctrl_DIV} !== 2'b10) begin
      bad++; $display("FAIL mult_ctrl_pulse: got %b want 10", {ctrl_MULT, ctrl_DIV});
    end
    total++;
    if (data_operandA !== 32'd6 || data_operandB !== 32'd7) begin
      bad++; $display("FAIL mult_operands: got %0d,%0d want 6,7", data_operandA, data_operandB);
    end
    tick();  // WAIT
    total++;
    if (ctrl_MULT !== 1'b0) begin bad++; $display("FAIL mult_ctrl_single: got %b want 0", ctrl_MULT); end
    for (int i = 0; i < 15; i++) begin
      if (stall !== 1'b1 || busy !== 1'b1) extra_stall_low++;
      if (wb_valid !== 1'b0) extra_valid++;
      tick();
    end
    total++;
    if (extra_stall_low != 0 || extra_valid != 0) begin
      bad++; $display("FAIL mult_wait_hold: got stall_low=%0d early_valid=%0d want 0,0",
                      extra_stall_low, extra_valid);
    end
    unit_ready = 1'b1; unit_result = 32'd42; unit_exception = 1'b0;
    tick();  // DONE
    unit_ready = 1'b0; unit_result = 32'hdead_beef;
    total++;
    if (wb_valid !== 1'b1 || wb_reg !== 5'd3 || wb_data !== 32'd42 || wb_exception !== 1'b0) begin
      bad++; $display("FAIL mult_wb: got v=%b reg=%0d data=%0d exc=%b want 1,3,42,0",
                      wb_valid, wb_reg, wb_data, wb_exception);
    end
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL mult_stall_done: got %b want 0", stall); end
    tick();  // IDLE
    total++;
    if (wb_valid !== 1'b0 || busy !== 1'b0 || wb_data !== 32'd42) begin
      bad++; $display("FAIL mult_after: got v=%b busy=%b data=%0d want 0,0,42",
                      wb_valid, busy, wb_data);
    end
  endtask

  task automatic test_div_zero();
    launch(1'b1, 32'd100, 32'd0, 5'd8);  // ISSUE
    total++;
    if ({ctrl_MULT, ctrl_DIV} !== 2'b01) begin
      bad++; $display("FAIL div0_ctrl_pulse: got %b want 01", {ctrl_MULT, ctrl_DIV});
    end
    tick();
    total++;
    if (ctrl_DIV !== 1'b0) begin bad++; $display("FAIL div0_ctrl_single: got %b want 0", ctrl_DIV); end
    tick(); tick();
    unit_ready = 1'b1; unit_exception = 1'b1; unit_result = 32'h1234;
    tick();  // DONE
    unit_ready = 1'b0; unit_exception = 1'b0;
    total++;
    if (wb_valid !== 1'b1 || wb_reg !== 5'd30 || wb_data !== 32'd5 || wb_exception !== 1'b1) begin
      bad++; $display("FAIL div0_wb: got v=%b reg=%0d data=%0d exc=%b want 1,30,5,1",
                      wb_valid, wb_reg, wb_data, wb_exception);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    launch(1'b0, 32'd3, 32'd4, 5'd2);
    tick(); tick();
    unit_ready = 1'b1; unit_result = 32'd12;
    tick();  // DONE of the multiply
    unit_ready = 1'b0;
    start = 1'b1; is_div = 1'b1; operand_a = 32'd100; operand_b = 32'd7; dest_reg = 5'd9;
    #1;
    total++;
    if (wb_valid !== 1'b1 || wb_data !== 32'd12 || stall !== 1'b1) begin
      bad++; $display("FAIL b2b_first_wb: got v=%b data=%0d stall=%b want 1,12,1",
                      wb_valid, wb_data, stall);
    end
    tick();  // ISSUE directly
    start = 1'b0;
    total++;
    if (ctrl_DIV !== 1'b1 || busy !== 1'b1 || data_operandA !== 32'd100 || data_operandB !== 32'd7) begin
      bad++; $display("FAIL b2b_issue: got div=%b busy=%b A=%0d B=%0d want 1,1,100,7",
                      ctrl_DIV, busy, data_operandA, data_operandB);
    end
    tick();
    unit_ready = 1'b1; unit_result = 32'd14;
    tick();
    unit_ready = 1'b0;
    total++;
    if (wb_valid !== 1'b1 || wb_reg !== 5'd9 || wb_data !== 32'd14 || wb_exception !== 1'b0) begin
      bad++; $display("FAIL b2b_second_wb: got v=%b reg=%0d data=%0d exc=%b want 1,9,14,0",
                      wb_valid, wb_reg, wb_data, wb_exception);
    end
    tick();
  endtask

  // Ready is held high from the start edge through ISSUE. It must be ignored.
  // This also covers dest_reg = 0, which still gets a writeback strobe.
  task automatic test_stale_ready();
    unit_ready = 1'b1; unit_result = 32'd99;
    launch(1'b0, 32'd5, 32'd11, 5'd0);  // ISSUE, ready still high
    tick();                              // WAIT
    unit_ready = 1'b0;
    total++;
    if (wb_valid !== 1'b0 || busy !== 1'b1 || stall !== 1'b1) begin
      bad++; $display("FAIL stale_ignored: got v=%b busy=%b stall=%b want 0,1,1",
                      wb_valid, busy, stall);
    end
    tick(); tick(); tick();
    total++;
    if (wb_valid !== 1'b0) begin bad++; $display("FAIL stale_no_wb: got %b want 0", wb_valid); end
    unit_ready = 1'b1; unit_result = 32'd55;
    tick();
    unit_ready = 1'b0;
    total++;
    if (wb_valid !== 1'b1 || wb_reg !== 5'd0 || wb_data !== 32'd55) begin
      bad++; $display("FAIL stale_real_wb: got v=%b reg=%0d data=%0d want 1,0,55",
                      wb_valid, wb_reg, wb_data);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    int ghost = 0;
    launch(1'b1, 32'd50, 32'd5, 5'd6);
    tick();                              // WAIT entry
    for (int i = 0; i < 4; i++) tick();  // 5 cycles into the operation
    reset = 1'b1;
    #1;
    total++;
    if ({ctrl_MULT, ctrl_DIV, busy, wb_valid, wb_exception, stall} !== 6'b0 ||
        data_operandA !== '0 || data_operandB !== '0 || wb_reg !== '0 || wb_data !== '0) begin
      bad++; $display("FAIL rst_wait_clear: got flags=%b A=%0d B=%0d reg=%0d data=%0d want all 0",
                      {ctrl_MULT, ctrl_DIV, busy, wb_valid, wb_exception, stall},
                      data_operandA, data_operandB, wb_reg, wb_data);
    end
    unit_ready = 1'b1; unit_result = 32'd10;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (wb_valid !== 1'b0 || busy !== 1'b0) ghost++;
    end
    unit_ready = 1'b0;
    total++;
    if (ghost != 0) begin bad++; $display("FAIL rst_stale_ready: got %0d bad cycles want 0", ghost); end
    tick();
  endtask

`ifdef MULTDIV_TIMEOUT_EN
  task automatic test_timeout();
    for (int d = 0; d < 2; d++) begin
      int n = 0;
      launch(d[0], 32'd1, 32'd2, 5'd7);  // ISSUE
      while (wb_valid !== 1'b1 && n < 80) begin
        tick();
        n++;
      end
      total++;
      if (n != 41) begin bad++; $display("FAIL timeout_cycles op%0d: got %0d want 41", d, n); end
      total++;
      if (wb_reg !== 5'd30 || wb_data !== (d == 1 ? 32'd5 : 32'd4) || wb_exception !== 1'b1) begin
        bad++; $display("FAIL timeout_wb op%0d: got reg=%0d data=%0d exc=%b want 30,%0d,1",
                        d, wb_reg, wb_data, wb_exception, (d == 1 ? 5 : 4));
      end
      tick();
    end
  endtask
`else
  task automatic test_no_timeout();
    int early = 0;
    launch(1'b0, 32'd9, 32'd9, 5'd12);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (wb_valid !== 1'b0 || busy !== 1'b1) early++;
    end
    total++;
    if (early != 0) begin bad++; $display("FAIL no_timeout_hold: got %0d bad cycles want 0", early); end
    unit_ready = 1'b1; unit_result = 32'd81;
    tick();
    unit_ready = 1'b0;
    total++;
    if (wb_valid !== 1'b1 || wb_reg !== 5'd12 || wb_data !== 32'd81 || wb_exception !== 1'b0) begin
      bad++; $display("FAIL no_timeout_wb: got v=%b reg=%0d data=%0d exc=%b want 1,12,81,0",
                      wb_valid, wb_reg, wb_data, wb_exception);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_multiply();
    test_div_zero();
    test_back_to_back();
    test_stale_ready();
    test_reset_mid_wait();
`ifdef MULTDIV_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
